// File: rtl/clk_wiz_0_lock_monitor.sv
// clk_wiz_0_lock_monitor
// Qualifies the MMCM lock status in the clk_out1 domain and issues a clean
// synchronous reset plus ready flag to downstream logic. Lock losses seen
// while running are counted in a saturating counter.
//
// Optional build macro: LOCK_MON_TIMEOUT_EN
//   When defined, adds parameter TIMEOUT_CYCLES and output port timeout,
//   a sticky flag raised when the monitor waits too long for lock.
module clk_wiz_0_lock_monitor #(
    parameter int SYNC_STAGES     = 2,
    parameter int STABLE_CYCLES   = 1024,
    parameter int RST_HOLD_CYCLES = 16,
    parameter int CNT_W           = 8
`ifdef LOCK_MON_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES  = 65536
`endif
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             locked,
    input  logic             input_clk_stopped,
    input  logic             counter_reset,
    output logic             rst_out,
    output logic             ready,
    output logic [CNT_W-1:0] lock_loss_count,
    output logic [1:0]       state
`ifdef LOCK_MON_TIMEOUT_EN
    ,
    output logic             timeout
`endif
);

    // Shared settle/hold counter must reach the larger of the two windows.
    localparam int MAX_CYC = (STABLE_CYCLES > RST_HOLD_CYCLES) ? STABLE_CYCLES : RST_HOLD_CYCLES;
    localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [CW-1:0]    STABLE_LAST = CW'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0]    HOLD_LAST   = CW'(RST_HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] LOSS_MAX    = '1;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'b00,
        SETTLE    = 2'b01,
        HOLD_RST  = 2'b10,
        RUN       = 2'b11
    } state_t;

    state_t           state_reg, state_next;
    logic [CW-1:0]    cnt_reg, cnt_next;
    logic [CNT_W-1:0] loss_reg, loss_next;

    logic [SYNC_STAGES-1:0] locked_sync_reg;
    logic [SYNC_STAGES-1:0] stopped_sync_reg;
    logic                   lock_ok;

    // Synchroniser chains: stage 0 samples the asynchronous pin, later stages
    // shift it along so metastability resolves before the FSM sees it.
    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                // First stage captures the raw asynchronous status.
                always_ff @(posedge clk or posedge reset) begin
                    if (reset) begin
                        locked_sync_reg[gi]  <= 1'b0;
                        stopped_sync_reg[gi] <= 1'b0;
                    end else begin
                        locked_sync_reg[gi]  <= locked;
                        stopped_sync_reg[gi] <= input_clk_stopped;
                    end
                end
            end else begin : g_next
                // Later stages copy the previous stage.
                always_ff @(posedge clk or posedge reset) begin
                    if (reset) begin
                        locked_sync_reg[gi]  <= 1'b0;
                        stopped_sync_reg[gi] <= 1'b0;
                    end else begin
                        locked_sync_reg[gi]  <= locked_sync_reg[gi-1];
                        stopped_sync_reg[gi] <= stopped_sync_reg[gi-1];
                    end
                end
            end
        end
    endgenerate

    assign lock_ok = locked_sync_reg[SYNC_STAGES-1] & ~stopped_sync_reg[SYNC_STAGES-1];

    // State, window counter and loss counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= WAIT_LOCK;
            cnt_reg   <= '0;
            loss_reg  <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            loss_reg  <= loss_next;
        end
    end

    // Next-state logic; a lock drop always takes priority over counter_reset.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        loss_next  = loss_reg;
        case (state_reg)
            WAIT_LOCK: begin
                if (lock_ok) begin
                    state_next = SETTLE;
                    cnt_next   = '0;
                end
            end
            SETTLE: begin
                if (!lock_ok) begin
                    state_next = WAIT_LOCK;
                    cnt_next   = '0;
                end else if (cnt_reg == STABLE_LAST) begin
                    state_next = HOLD_RST;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            HOLD_RST: begin
                if (!lock_ok) begin
                    state_next = WAIT_LOCK;
                    cnt_next   = '0;
                end else if (counter_reset) begin
                    cnt_next = '0;
                end else if (cnt_reg == HOLD_LAST) begin
                    state_next = RUN;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            RUN: begin
                if (!lock_ok) begin
                    state_next = WAIT_LOCK;
                    cnt_next   = '0;
                    if (loss_reg != LOSS_MAX) begin
                        loss_next = loss_reg + CNT_W'(1);
                    end
                end else if (counter_reset) begin
                    state_next = HOLD_RST;
                    cnt_next   = '0;
                end
            end
            default: begin
                state_next = WAIT_LOCK;
                cnt_next   = '0;
            end
        endcase
    end

    assign rst_out         = (state_reg != RUN);
    assign ready           = (state_reg == RUN);
    assign lock_loss_count = loss_reg;
    assign state           = state_reg;

`ifdef LOCK_MON_TIMEOUT_EN
    localparam int            TW      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] tcnt_reg;
    logic          timeout_reg;

    // Wait-for-lock watchdog: counts only in WAIT_LOCK, flag is sticky until
    // the monitor reaches RUN again.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tcnt_reg    <= '0;
            timeout_reg <= 1'b0;
        end else begin
            if (state_reg == WAIT_LOCK) begin
                if (tcnt_reg == TO_LAST) begin
                    timeout_reg <= 1'b1;
                end else begin
                    tcnt_reg <= tcnt_reg + TW'(1);
                end
            end else begin
                tcnt_reg <= '0;
            end
            if (state_next == RUN && state_reg != RUN) begin
                timeout_reg <= 1'b0;
            end
        end
    end

    assign timeout = timeout_reg;
`endif

endmodule
